// File: rtl/score_keeper.sv
// score_keeper: per-song accumulator that waits for the Scoring pipeline to
// settle after each hit, then commits base/bonus/combo into running totals.
module score_keeper #(
   parameter int SETTLE     = 3,
   parameter int MISS_LIMIT = 8,
   parameter int W          = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] total_note,
   input  logic [1:0]   mod,
   input  logic         hit_valid,
   input  logic [W-1:0] base_score,
   input  logic [W-1:0] bonus_score,
   input  logic [W-1:0] combo,
   output logic [W-1:0] last_combo,
   output logic [W-1:0] last_base_score,
   output logic [W-1:0] now_cnt,
   output logic [W-1:0] bonus_total,
   output logic [W-1:0] total_score,
   output logic [W-1:0] max_combo,
   output logic         busy,
   output logic         hit_ack,
   output logic         song_done,
   output logic         fail,
   output logic [2:0]   state_dbg
);

   // Handshake: hit_valid is a one-cycle strobe accepted only in RUN; no
   // back-pressure exists, so a strobe arriving outside RUN is dropped.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RUN    = 3'd1,
      S_SETTLE = 3'd2,
      S_COMMIT = 3'd3,
      S_DONE   = 3'd4,
      S_FAILED = 3'd5
   } state_t;

   localparam int CW = $clog2(SETTLE) + 1;
   localparam logic [W-1:0] MAX_VAL = '1;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   settle_cnt;
   logic [W-1:0]    miss_cnt;
   logic [W-1:0]    total_note_q;
   logic [1:0]      mod_q;

   logic [W:0]      base_sum;
   logic [W:0]      bonus_sum;
   logic [W:0]      total_sum;
   logic [W-1:0]    base_sat;
   logic [W-1:0]    bonus_sat;
   logic [W-1:0]    total_sat;
   logic [W-1:0]    miss_upd;
   logic [W-1:0]    cnt_upd;

   always_comb begin
      base_sum  = {1'b0, last_base_score} + {1'b0, base_score};
      bonus_sum = {1'b0, bonus_total} + {1'b0, bonus_score};
      total_sum = {1'b0, last_base_score} + {1'b0, bonus_total};
      base_sat  = base_sum[W]  ? MAX_VAL : base_sum[W-1:0];
      bonus_sat = bonus_sum[W] ? MAX_VAL : bonus_sum[W-1:0];
      total_sat = total_sum[W] ? MAX_VAL : total_sum[W-1:0];
      // Miss counter saturates so a long No Fail streak cannot wrap back under the limit.
      if (base_score != '0)
         miss_upd = '0;
      else if (miss_cnt == MAX_VAL)
         miss_upd = miss_cnt;
      else
         miss_upd = miss_cnt + 1'b1;
      cnt_upd = now_cnt + 1'b1;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:   state_nxt = S_IDLE;
         S_RUN:    if (hit_valid) state_nxt = S_SETTLE;
         S_SETTLE: if (settle_cnt == '0) state_nxt = S_COMMIT;
         S_COMMIT: begin
            if (mod_q != 2'b01 && miss_upd >= W'(MISS_LIMIT))
               state_nxt = S_FAILED;
            else if (cnt_upd == total_note_q)
               state_nxt = S_DONE;
            else
               state_nxt = S_RUN;
         end
         S_DONE:   state_nxt = S_DONE;
         S_FAILED: state_nxt = S_FAILED;
         default:  state_nxt = S_IDLE;
      endcase
      if (start)
         state_nxt = (total_note == '0) ? S_DONE : S_RUN;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         settle_cnt      <= '0;
         miss_cnt        <= '0;
         total_note_q    <= '0;
         mod_q           <= '0;
         last_combo      <= '0;
         last_base_score <= '0;
         now_cnt         <= '0;
         bonus_total     <= '0;
         total_score     <= '0;
         max_combo       <= '0;
      end else if (start) begin
         settle_cnt      <= '0;
         miss_cnt        <= '0;
         total_note_q    <= total_note;
         mod_q           <= mod;
         last_combo      <= '0;
         last_base_score <= '0;
         now_cnt         <= '0;
         bonus_total     <= '0;
         total_score     <= '0;
         max_combo       <= '0;
      end else begin
         total_score <= total_sat;
         if (state == S_RUN && hit_valid)
            settle_cnt <= CW'(SETTLE - 1);
         else if (state == S_SETTLE && settle_cnt != '0)
            settle_cnt <= settle_cnt - 1'b1;
         // Scoring outputs are only trusted here, once the pipeline has settled.
         if (state == S_COMMIT) begin
            last_base_score <= base_sat;
            bonus_total     <= bonus_sat;
            last_combo      <= combo;
            if (combo > max_combo)
               max_combo <= combo;
            now_cnt  <= cnt_upd;
            miss_cnt <= miss_upd;
         end
      end
   end

   assign busy      = (state == S_SETTLE) || (state == S_COMMIT);
   assign hit_ack   = (state == S_COMMIT);
   assign song_done = (state == S_DONE);
   assign fail      = (state == S_FAILED);
   assign state_dbg = state;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: event-level model of song/hit bookkeeping checked
// every cycle, plus directed scenarios with hand-computed totals.
module tb_score_keeper;

   localparam int W          = 10;
   localparam int SETTLE     = 3;
   localparam int MISS_LIMIT = 8;
   localparam longint MAXV   = (longint'(1) << W) - 1;

   localparam logic [31:0] ST_IDLE   = 32'd0;
   localparam logic [31:0] ST_RUN    = 32'd1;
   localparam logic [31:0] ST_SETTLE = 32'd2;
   localparam logic [31:0] ST_COMMIT = 32'd3;
   localparam logic [31:0] ST_DONE   = 32'd4;
   localparam logic [31:0] ST_FAILED = 32'd5;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] total_note;
   logic [1:0]   mod;
   logic         hit_valid;
   logic [W-1:0] base_score;
   logic [W-1:0] bonus_score;
   logic [W-1:0] combo;
   logic [W-1:0] last_combo;
   logic [W-1:0] last_base_score;
   logic [W-1:0] now_cnt;
   logic [W-1:0] bonus_total;
   logic [W-1:0] total_score;
   logic [W-1:0] max_combo;
   logic         busy;
   logic         hit_ack;
   logic         song_done;
   logic         fail;
   logic [2:0]   state_dbg;

   score_keeper #(.SETTLE(SETTLE), .MISS_LIMIT(MISS_LIMIT), .W(W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .total_note      (total_note),
      .mod             (mod),
      .hit_valid       (hit_valid),
      .base_score      (base_score),
      .bonus_score     (bonus_score),
      .combo           (combo),
      .last_combo      (last_combo),
      .last_base_score (last_base_score),
      .now_cnt         (now_cnt),
      .bonus_total     (bonus_total),
      .total_score     (total_score),
      .max_combo       (max_combo),
      .busy            (busy),
      .hit_ack         (hit_ack),
      .song_done       (song_done),
      .fail            (fail),
      .state_dbg       (state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int ack_count = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic longint sat(input longint v);
      return (v > MAXV) ? MAXV : v;
   endfunction

   // model: song phase (0 idle, 1 playing, 2 done, 3 failed) plus the edge
   // at which a pending hit commits
   longint cyc = 0;
   longint pend = -1;
   int     m_phase = 0;
   longint m_base = 0, m_bonus = 0, m_total = 0, m_last = 0, m_max = 0;
   longint m_cnt = 0, m_miss = 0, m_tn = 0;
   int     m_mod = 0;
   logic [31:0] exp_q[$];

   always @(posedge clk) begin
      longint tot_next;
      logic [31:0] exp_state;
      tot_next = sat(m_base + m_bonus);
      if (!rst_n || start) begin
         m_base = 0; m_bonus = 0; m_last = 0; m_max = 0; m_cnt = 0; m_miss = 0;
         pend = -1; tot_next = 0; exp_q.delete();
         if (!rst_n) begin
            m_phase = 0; m_tn = 0; m_mod = 0;
         end else begin
            m_tn = longint'(total_note); m_mod = int'(mod);
            m_phase = (total_note == 0) ? 2 : 1;
         end
      end else if (pend >= 0 && cyc == pend) begin
         m_base  = sat(m_base + longint'(base_score));
         m_bonus = sat(m_bonus + longint'(bonus_score));
         m_last  = longint'(combo);
         if (longint'(combo) > m_max) m_max = longint'(combo);
         m_cnt++;
         m_miss = (base_score == 0) ? m_miss + 1 : 0;
         pend = -1;
         if (m_mod != 1 && m_miss >= MISS_LIMIT) m_phase = 3;
         else if (m_cnt == m_tn) m_phase = 2;
      end else if (hit_valid && m_phase == 1 && pend < 0) begin
         pend = cyc + SETTLE + 1;
         exp_q.push_back(32'(pend));
      end
      m_total = tot_next;
      cyc++;

      #1;
      if (pend >= 0)
         exp_state = (pend == cyc) ? ST_COMMIT : ST_SETTLE;
      else
         case (m_phase)
            1: exp_state = ST_RUN;
            2: exp_state = ST_DONE;
            3: exp_state = ST_FAILED;
            default: exp_state = ST_IDLE;
         endcase
      chk("last_combo",      32'(last_combo),      32'(m_last));
      chk("last_base_score", 32'(last_base_score), 32'(m_base));
      chk("now_cnt",         32'(now_cnt),         32'(m_cnt));
      chk("bonus_total",     32'(bonus_total),     32'(m_bonus));
      chk("total_score",     32'(total_score),     32'(m_total));
      chk("max_combo",       32'(max_combo),       32'(m_max));
      chk("busy",            32'(busy),            32'(pend >= 0));
      chk("hit_ack",         32'(hit_ack),         32'(pend >= 0 && pend == cyc));
      chk("song_done",       32'(song_done),       32'(m_phase == 2 && pend < 0));
      chk("fail",            32'(fail),            32'(m_phase == 3 && pend < 0));
      chk("state",           32'(state_dbg),       exp_state);
      // scoreboard: every ack must match the queued commit edge of an accepted hit
      if (hit_ack === 1'b1) begin
         ack_count++;
         if (exp_q.size() == 0) chk("unexpected_ack", 32'(cyc), 32'hffff_ffff);
         else                   chk("ack_cycle", 32'(cyc), exp_q.pop_front());
      end
   end

   // driver tasks (entered and left at a falling edge)
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_start(input int tn, input logic [1:0] md);
      start = 1'b1; total_note = W'(tn); mod = md;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_hit(input int b, input int bo, input int c, input int gap);
      hit_valid = 1'b1; base_score = W'(b); bonus_score = W'(bo); combo = W'(c);
      @(negedge clk);
      hit_valid = 1'b0;
      tick(gap - 1);
   endtask

   int ack_base;

   initial begin
      rst_n = 1'b0; start = 1'b0; total_note = '0; mod = '0; hit_valid = 1'b0;
      base_score = '0; bonus_score = '0; combo = '0;
      tick(3);
      rst_n = 1'b1;
      chk("lit_reset_state", 32'(state_dbg), ST_IDLE);
      chk("lit_reset_total", 32'(total_score), 32'd0);

      // three normal hits
      ack_base = ack_count;
      do_start(3, 2'b00);
      do_hit(100, 10, 1, 6);
      do_hit(100, 10, 2, 6);
      do_hit(100, 10, 3, 6);
      tick(2);
      chk("lit_s1_now_cnt", 32'(now_cnt), 32'd3);
      chk("lit_s1_base",    32'(last_base_score), 32'd300);
      chk("lit_s1_bonus",   32'(bonus_total), 32'd30);
      chk("lit_s1_total",   32'(total_score), 32'd330);
      chk("lit_s1_max",     32'(max_combo), 32'd3);
      chk("lit_s1_done",    32'(song_done), 32'd1);
      chk("lit_s1_busy",    32'(busy), 32'd0);
      chk("lit_s1_acks",    32'(ack_count - ack_base), 32'd3);

      // too-fast hits are dropped
      ack_base = ack_count;
      do_start(5, 2'b00);
      hit_valid = 1'b1; base_score = 10'd7; bonus_score = 10'd1; combo = 10'd1;
      tick(2);
      hit_valid = 1'b0;
      tick(1);
      hit_valid = 1'b1;
      tick(1);
      hit_valid = 1'b0;
      tick(8);
      chk("lit_s2_now_cnt", 32'(now_cnt), 32'd1);
      chk("lit_s2_acks",    32'(ack_count - ack_base), 32'd1);

      // miss limit, Normal mode
      do_start(20, 2'b00);
      repeat (8) do_hit(0, 0, 0, 6);
      chk("lit_s3_fail",    32'(fail), 32'd1);
      chk("lit_s3_now_cnt", 32'(now_cnt), 32'd8);
      do_hit(50, 5, 1, 6);
      chk("lit_s3_ignored", 32'(now_cnt), 32'd8);
      chk("lit_s3_state",   32'(state_dbg), ST_FAILED);

      // miss limit, No Fail mode
      do_start(20, 2'b01);
      repeat (8) do_hit(0, 0, 0, 6);
      chk("lit_s3b_fail",    32'(fail), 32'd0);
      chk("lit_s3b_now_cnt", 32'(now_cnt), 32'd8);
      chk("lit_s3b_state",   32'(state_dbg), ST_RUN);

      // saturation at 2^W-1
      do_start(5, 2'b00);
      do_hit(500, 100, 1, 6);
      do_hit(500, 100, 2, 6);
      do_hit(500, 100, 3, 6);
      tick(2);
      chk("lit_s4_base",  32'(last_base_score), 32'(MAXV));
      chk("lit_s4_bonus", 32'(bonus_total), 32'd300);
      chk("lit_s4_total", 32'(total_score), 32'(MAXV));

      // start while a hit is settling
      ack_base = ack_count;
      do_start(5, 2'b00);
      hit_valid = 1'b1; base_score = 10'd50; bonus_score = 10'd5; combo = 10'd4;
      tick(1);
      hit_valid = 1'b0;
      tick(1);
      chk("lit_s5_busy", 32'(busy), 32'd1);
      do_start(4, 2'b00);
      tick(6);
      chk("lit_s5_now_cnt", 32'(now_cnt), 32'd0);
      chk("lit_s5_base",    32'(last_base_score), 32'd0);
      chk("lit_s5_state",   32'(state_dbg), ST_RUN);
      chk("lit_s5_acks",    32'(ack_count - ack_base), 32'd0);

      // empty song finishes immediately
      do_start(0, 2'b00);
      chk("lit_s6_done", 32'(song_done), 32'd1);

      // combo tracking, then reset mid-settle
      do_start(5, 2'b00);
      do_hit(10, 0, 5, 6);
      do_hit(10, 0, 0, 6);
      do_hit(10, 0, 2, 6);
      chk("lit_s7_max",  32'(max_combo), 32'd5);
      chk("lit_s7_last", 32'(last_combo), 32'd2);
      hit_valid = 1'b1; base_score = 10'd40;
      tick(1);
      hit_valid = 1'b0;
      tick(1);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      chk("lit_s7_state", 32'(state_dbg), ST_IDLE);
      chk("lit_s7_base",  32'(last_base_score), 32'd0);
      chk("lit_s7_busy",  32'(busy), 32'd0);
      tick(6);
      chk("lit_s7_now_cnt", 32'(now_cnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
